// File: rtl/ytydla_cmac_fetch.sv
// ytydla_cmac_fetch: reads S data then S weight words into two lane banks
// and offers them to ytydla_cmac on a valid/ready handshake.
// Ports: clk/rst, cfg_* command (start, addrs, size, busy, err),
//   mem_rd_* word read port (1-cycle data latency),
//   fetch2cmac_* output banks, size and handshake.
// Option: YTYDLA_FETCH_ZERO_PAD_EN masks lanes >= Seff to 0 on the outputs.
module ytydla_cmac_fetch #(
  parameter int LANES = 64,
  parameter int DW    = 32,
  parameter int AW    = 16
) (
  input  logic                ytydla_core_clk,
  input  logic                ytydla_core_rst,
  input  logic                cfg_start,
  input  logic [AW-1:0]       cfg_dat_addr,
  input  logic [AW-1:0]       cfg_wt_addr,
  input  logic [6:0]          cfg_size,
  output logic                cfg_busy,
  output logic                cfg_err,
  output logic                mem_rd_en,
  output logic [AW-1:0]       mem_rd_addr,
  input  logic [DW-1:0]       mem_rd_data,
  output logic                fetch2cmac_valid,
  input  logic                fetch2cmac_ready,
  output logic [LANES*DW-1:0] fetch2cmac_dat,
  output logic [LANES*DW-1:0] fetch2cmac_wt,
  output logic [31:0]         fetch2cmac_size
);

  localparam int LW = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DAT,
    S_WT,
    S_LAST,
    S_HOLD
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  dat_base;
  logic [AW-1:0]  wt_base;
  logic [6:0]     seff;
  logic [6:0]     cnt;
  logic [6:0]     cnt_nxt;
  logic [6:0]     size_clip;
  logic           accept;
  logic           last_rd;
  logic           cap_vld;
  logic           cap_wt;
  logic [LW-1:0]  cap_lane;
  logic [DW-1:0]  dat_bank [LANES];
  logic [DW-1:0]  wt_bank  [LANES];

  assign size_clip = (cfg_size > 7'(LANES)) ? 7'(LANES) : cfg_size;
  assign accept    = (state == S_IDLE) && cfg_start
                     && (cfg_size != 7'd0);
  assign last_rd   = (cnt == seff - 7'd1);

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    mem_rd_en        = 1'b0;
    mem_rd_addr      = '0;
    fetch2cmac_valid = 1'b0;
    cfg_busy         = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_DAT;
          cnt_nxt   = 7'd0;
        end
      end
      S_DAT: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = dat_base + AW'(cnt);
        cnt_nxt     = cnt + 7'd1;
        if (last_rd) begin
          cnt_nxt   = 7'd0;
          state_nxt = S_WT;
        end
      end
      S_WT: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = wt_base + AW'(cnt);
        cnt_nxt     = cnt + 7'd1;
        if (last_rd) begin
          cnt_nxt   = 7'd0;
          state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        fetch2cmac_valid = 1'b1;
        if (fetch2cmac_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ytydla_core_clk) begin
    if (ytydla_core_rst) begin
      state    <= S_IDLE;
      cnt      <= 7'd0;
      dat_base <= '0;
      wt_base  <= '0;
      seff     <= 7'd0;
      cfg_err  <= 1'b0;
      cap_vld  <= 1'b0;
      cap_wt   <= 1'b0;
      cap_lane <= '0;
      for (int i = 0; i < LANES; i++) begin
        dat_bank[i] <= '0;
        wt_bank[i]  <= '0;
      end
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cfg_err <= (state == S_IDLE) && cfg_start
                 && (cfg_size == 7'd0);
      if (accept) begin
        dat_base <= cfg_dat_addr;
        wt_base  <= cfg_wt_addr;
        seff     <= size_clip;
      end
      // Tag each read with its bank/lane; data lands one cycle later.
      cap_vld  <= mem_rd_en;
      cap_wt   <= (state == S_WT);
      cap_lane <= cnt[LW-1:0];
      if (cap_vld) begin
        if (cap_wt) begin
          wt_bank[cap_lane]  <= mem_rd_data;
        end else begin
          dat_bank[cap_lane] <= mem_rd_data;
        end
      end
    end
  end

  always_comb begin
    fetch2cmac_dat = '0;
    fetch2cmac_wt  = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef YTYDLA_FETCH_ZERO_PAD_EN
      if (i < int'(seff)) begin
        fetch2cmac_dat[i*DW +: DW] = dat_bank[i];
        fetch2cmac_wt[i*DW +: DW]  = wt_bank[i];
      end
`else
      fetch2cmac_dat[i*DW +: DW] = dat_bank[i];
      fetch2cmac_wt[i*DW +: DW]  = wt_bank[i];
`endif
    end
  end

  assign fetch2cmac_size = 32'(seff);

endmodule

// File: tb/tb_ytydla_cmac_fetch.sv
// tb_ytydla_cmac_fetch: directed + randomized bench for ytydla_cmac_fetch
// against a memory/bank reference model.
module tb_ytydla_cmac_fetch;

  localparam int LANES = 64;
  localparam int DW    = 32;
  localparam int AW    = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_start = 1'b0;
  logic [AW-1:0]       cfg_dat_addr = '0;
  logic [AW-1:0]       cfg_wt_addr = '0;
  logic [6:0]          cfg_size = '0;
  logic                cfg_busy;
  logic                cfg_err;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_rd_addr;
  logic [DW-1:0]       mem_rd_data = '0;
  logic                valid;
  logic                ready = 1'b0;
  logic [LANES*DW-1:0] o_dat;
  logic [LANES*DW-1:0] o_wt;
  logic [31:0]         o_size;

  ytydla_cmac_fetch #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .ytydla_core_clk  (clk),
    .ytydla_core_rst  (rst),
    .cfg_start        (cfg_start),
    .cfg_dat_addr     (cfg_dat_addr),
    .cfg_wt_addr      (cfg_wt_addr),
    .cfg_size         (cfg_size),
    .cfg_busy         (cfg_busy),
    .cfg_err          (cfg_err),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data      (mem_rd_data),
    .fetch2cmac_valid (valid),
    .fetch2cmac_ready (ready),
    .fetch2cmac_dat   (o_dat),
    .fetch2cmac_wt    (o_wt),
    .fetch2cmac_size  (o_size)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [65536];
  logic [DW-1:0] mdl_dat [LANES];
  logic [DW-1:0] mdl_wt  [LANES];
  logic [AW-1:0] rd_log [$];
  int            hs_cnt = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  int            mdl_seff = 0;

  // Memory: data appears one cycle after the strobe; garbage otherwise.
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : $urandom;
    if (!rst && mem_rd_en) rd_log.push_back(mem_rd_addr);
    if (!rst && valid && ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_banks(input string tag);
    int bd;
    int bw;
    logic [DW-1:0] ed;
    logic [DW-1:0] ew;
    bd = 0;
    bw = 0;
    for (int i = 0; i < LANES; i++) begin
      ed = mdl_dat[i];
      ew = mdl_wt[i];
`ifdef YTYDLA_FETCH_ZERO_PAD_EN
      if (i >= mdl_seff) begin
        ed = '0;
        ew = '0;
      end
`endif
      if (o_dat[i*DW +: DW] !== ed) bd++;
      if (o_wt[i*DW +: DW] !== ew) bw++;
    end
    chk({tag, "_dat_bad_lanes"}, 64'(bd), 64'd0);
    chk({tag, "_wt_bad_lanes"}, 64'(bw), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [AW-1:0] da,
                       input logic [AW-1:0] wa, input logic [6:0] s,
                       input int hold, input bit poke);
    int se;
    int n;
    int rb;
    int hb;
    int bad;
    logic [AW-1:0] eq [$];
    se = (s > 7'd64) ? 64 : int'(s);
    for (int k = 0; k < se; k++) eq.push_back(AW'(int'(da) + k));
    for (int k = 0; k < se; k++) eq.push_back(AW'(int'(wa) + k));
    rb = rd_log.size();
    hb = hs_cnt;
    ready = (hold == 0);
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_dat_addr = da;
    cfg_wt_addr = wa;
    cfg_size = s;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_dat_addr = AW'($urandom);
    cfg_wt_addr = AW'($urandom);
    cfg_size = 7'($urandom);
    n = 1;
    chk({tag, "_busy"}, 64'(cfg_busy), 64'd1);
    while (!valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(2 * se + 2));
    for (int i = 0; i < se; i++) begin
      mdl_dat[i] = mem[AW'(int'(da) + i)];
      mdl_wt[i]  = mem[AW'(int'(wa) + i)];
    end
    mdl_seff = se;
    chk({tag, "_size"}, 64'(o_size), 64'(se));
    chk({tag, "_nreads"}, 64'(rd_log.size() - rb), 64'(eq.size()));
    bad = 0;
    for (int k = 0; k < eq.size() && rb + k < rd_log.size(); k++)
      if (rd_log[rb + k] !== eq[k]) bad++;
    chk({tag, "_bad_addrs"}, 64'(bad), 64'd0);
    chk_banks(tag);
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 2) begin
        cfg_start = 1'b1;
        cfg_size = 7'd5;
      end
      @(negedge clk);
      cfg_start = 1'b0;
      chk({tag, "_hold_valid"}, 64'(valid), 64'd1);
      chk({tag, "_hold_size"}, 64'(o_size), 64'(se));
      chk_banks({tag, "_hold"});
    end
    ready = 1'b1;
    if (poke) begin
      cfg_start = 1'b1;
      cfg_size = 7'd7;
    end
    @(negedge clk);
    cfg_start = 1'b0;
    chk({tag, "_valid_drop"}, 64'(valid), 64'd0);
    chk({tag, "_busy_drop"}, 64'(cfg_busy), 64'd0);
    chk({tag, "_handshakes"}, 64'(hs_cnt - hb), 64'd1);
    if (poke) begin
      @(negedge clk);
      chk({tag, "_poke_idle"}, 64'(cfg_busy), 64'd0);
      chk({tag, "_poke_reads"}, 64'(rd_log.size() - rb), 64'(eq.size()));
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_busy"}, 64'(cfg_busy), 64'd0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_err"}, 64'(cfg_err), 64'd0);
    chk({tag, "_size"}, 64'(o_size), 64'd0);
    for (int i = 0; i < LANES; i++) begin
      mdl_dat[i] = '0;
      mdl_wt[i] = '0;
    end
    mdl_seff = 0;
    chk_banks(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb;
    int s5;
    int n;
    logic [AW-1:0] ra;
    logic [AW-1:0] rw;
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    do_op("t1", 16'h00CA, 16'h0310, 7'd25, 0, 1'b0);

    ra = AW'($urandom);
    rw = AW'($urandom);
    do_op("t2", ra, rw, 7'd64, 10, 1'b0);

    ra = AW'($urandom);
    rw = AW'($urandom);
    do_op("t3", ra, rw, 7'd100, 0, 1'b0);

    rb = rd_log.size();
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_size = 7'd0;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("s0_err_pulse", 64'(cfg_err), 64'd1);
    chk("s0_busy", 64'(cfg_busy), 64'd0);
    @(negedge clk);
    chk("s0_err_clear", 64'(cfg_err), 64'd0);
    chk("s0_busy2", 64'(cfg_busy), 64'd0);
    chk("s0_reads", 64'(rd_log.size() - rb), 64'd0);

    do_op("t4", 16'hFFFE, AW'($urandom), 7'd4, 0, 1'b0);

    s5 = 10 + int'($urandom_range(30));
    ready = 1'b1;
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_dat_addr = AW'($urandom);
    cfg_wt_addr = AW'($urandom);
    cfg_size = 7'(s5);
    @(negedge clk);
    cfg_start = 1'b0;
    n = 1;
    while (n < s5 + 1 + s5 / 2) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_wt_rd_en", 64'(mem_rd_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rb = rd_log.size();
    chk_idle_zero("t5_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_no_reads", 64'(rd_log.size() - rb), 64'd0);
    do_op("t5_s3", AW'($urandom), AW'($urandom), 7'd3, 0, 1'b0);

    for (int k = 0; k < 64; k++) begin
      mem[16'h4000 + k] = 32'hFFFF_FFFF;
      mem[16'h5000 + k] = 32'hFFFF_FFFF;
    end
    do_op("t6_full", 16'h4000, 16'h5000, 7'd64, 0, 1'b0);
    do_op("t6_s2", 16'h6000, 16'h7000, 7'd2, 5, 1'b1);

    for (int r = 0; r < 4; r++) begin
      do_op("rnd", AW'($urandom), AW'($urandom),
            7'($urandom_range(127, 1)), int'($urandom_range(3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
